ll_link_bringup: RTL and testbench
==================================

// Module: ll_link_bringup
// PURPOSE
//   Link bring-up sequencer that sits directly upstream of the auto-sync / online-delay stage.
//   - Qualifies PHY readiness and raises tx_online.
//   - Waits for a stable run of good received markers, then raises rx_online.
//   - Drops both onlines and retrains on marker loss, alignment timeout or PHY drop.
//   tx_online and rx_online feed the logic-link top directly.
// PARAMETERS
//   STABLE_CYCLES  16    consecutive phy_ready cycles required before tx_online
//   ALIGN_GOOD     8     consecutive rx_mrk_ok cycles required before rx_online
//   ALIGN_TIMEOUT  1024  max cycles spent in ALIGN before retrain
//   MRK_LOSS_MAX   4     consecutive rx_mrk_err cycles in ONLINE that force retrain
//   RETRAIN_GAP    32    cycles both onlines are held low in RETRAIN
// PORTS
//   clk_wr         in   1   clock
//   rst_wr         in   1   synchronous reset, active-high
//   link_enable    in   1   software enable; low forces IDLE
//   phy_ready      in   1   AIB adapter/PHY ready
//   rx_mrk_ok      in   1   pulse: received word carried correct marker this cycle
//   rx_mrk_err     in   1   pulse: received word carried bad or missing marker
//   err_clr        in   1   clears timeout_err
//   tx_online      out  1   to auto-sync tx_online
//   rx_online      out  1   to auto-sync rx_online
//   link_state     out  3   current state encoding
//   timeout_err    out  1   sticky: ALIGN timed out
//   retrain_count  out  8   saturating count of RETRAIN entries
// BEHAVIOUR
//   Reset (rst_wr=1 at clk_wr edge): all outputs 0, state IDLE, all counters 0.
//   All outputs are registered / Moore-decoded from the state register.
//   State encoding: IDLE=0, PHY_WAIT=1, ALIGN=2, ONLINE=3, RETRAIN=4.
//   Output decode:
//   - tx_online=1 only in ALIGN and ONLINE.
//   - rx_online=1 only in ONLINE.
//   Priority, evaluated every cycle:
//   - link_enable=0 -> IDLE next cycle from any state (highest priority).
//   - phy_ready=0 while in ALIGN or ONLINE -> RETRAIN.
//   IDLE: link_enable=1 -> PHY_WAIT.
//   PHY_WAIT:
//   - stab_cnt increments while phy_ready=1 and clears to 0 when phy_ready=0.
//   - stab_cnt==STABLE_CYCLES-1 with phy_ready=1 -> ALIGN (exactly STABLE_CYCLES high cycles).
//   ALIGN:
//   - good_cnt counts consecutive rx_mrk_ok and clears on rx_mrk_err.
//   - Cycles with neither ok nor err hold good_cnt.
//   - good_cnt==ALIGN_GOOD-1 with rx_mrk_ok=1 -> ONLINE.
//   - tmo_cnt increments every ALIGN cycle. tmo_cnt==ALIGN_TIMEOUT-1 -> RETRAIN and set timeout_err.
//   - If the ONLINE and timeout conditions hit in the same cycle, ONLINE wins.
//   ONLINE:
//   - loss_cnt counts consecutive rx_mrk_err; rx_mrk_ok clears it.
//   - loss_cnt==MRK_LOSS_MAX-1 with rx_mrk_err=1 -> RETRAIN.
//   RETRAIN:
//   - Entering increments retrain_count, saturating at 255.
//   - gap_cnt runs to RETRAIN_GAP-1, then -> PHY_WAIT.
//   Counter rules:
//   - Every counter clears on entry to any state.
//   - Counter width is $clog2(max param)+1; counters never wrap.
//   rx_mrk_ok and rx_mrk_err asserted in the same cycle: treated as err.
//   timeout_err: set has priority over err_clr in the same cycle; cleared only by err_clr or rst_wr.
//   Reset mid-operation: onlines drop in the cycle after the reset edge; no partial state survives.
// STRUCTURE
//   ll_bringup_pkg:
//   - typedef enum logic [2:0] bringup_state_t (encodings above).
//   - default parameter constants.
//   - function cnt_width().
//   Sub-module ll_run_counter, instantiated 3x for stab/good/loss:
//   - consecutive-event counter with inputs inc, clr, hold.
//   - outputs count and hit (count==TARGET-1 && inc).
//   tmo_cnt, gap_cnt and retrain_count stay inline.
// TESTING
//   1. Nominal bring-up, defaults:
//      - link_enable=1, phy_ready=1 -> tx_online rises 17 cycles after enable (1 IDLE + 16 PHY_WAIT).
//      - 8 rx_mrk_ok pulses -> rx_online=1 on the next cycle; link_state=3.
//   2. PHY glitch: phy_ready low for 1 cycle at PHY_WAIT count 10 -> count restarts; tx_online delayed by 11 cycles.
//   3. Align timeout: no rx_mrk_ok for 1024 ALIGN cycles ->
//      - timeout_err=1, tx_online=0, retrain_count=1.
//      - PHY_WAIT re-entered after 32 cycles.
//   4. Marker loss: in ONLINE,
//      - 3 errs, 1 ok, 3 errs -> stays ONLINE.
//      - 4 consecutive errs -> rx_online and tx_online drop next cycle.
//   5. Priority: link_enable=0 in the same cycle as phy_ready=0 while ONLINE -> IDLE (not RETRAIN); retrain_count unchanged.
//   6. Saturation and reset:
//      - force 260 retrains -> retrain_count==255.
//      - rst_wr asserted mid-ALIGN -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/ll_bringup_pkg.sv
// Shared types and defaults for the link bring-up sequencer.
package ll_bringup_pkg;

   typedef enum logic [2:0] {
      BsIdle    = 3'd0,
      BsPhyWait = 3'd1,
      BsAlign   = 3'd2,
      BsOnline  = 3'd3,
      BsRetrain = 3'd4
   } bringup_state_t;

   localparam int unsigned StateW           = 3;
   localparam int unsigned RetrainCntW      = 8;
   localparam int unsigned DefStableCycles  = 16;
   localparam int unsigned DefAlignGood     = 8;
   localparam int unsigned DefAlignTimeout  = 1024;
   localparam int unsigned DefMrkLossMax    = 4;
   localparam int unsigned DefRetrainGap    = 32;

   // One shared width sized for the largest target so no counter can wrap.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d,
                                             input int unsigned e);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/ll_link_bringup_if.sv
// Control/status bundle between software/PHY side and the bring-up sequencer.
interface ll_link_bringup_if;
   import ll_bringup_pkg::*;

   logic                   link_enable;
   logic                   phy_ready;
   logic                   rx_mrk_ok;
   logic                   rx_mrk_err;
   logic                   err_clr;
   logic                   tx_online;
   logic                   rx_online;
   logic [StateW-1:0]      link_state;
   logic                   timeout_err;
   logic [RetrainCntW-1:0] retrain_count;

   modport master (
      output link_enable, phy_ready, rx_mrk_ok, rx_mrk_err, err_clr,
      input  tx_online, rx_online, link_state, timeout_err, retrain_count
   );

   modport slave (
      input  link_enable, phy_ready, rx_mrk_ok, rx_mrk_err, err_clr,
      output tx_online, rx_online, link_state, timeout_err, retrain_count
   );

endinterface

// File: rtl/ll_run_counter.sv
// Consecutive-event counter: clr wins, inc counts, otherwise hold or reset to zero.
module ll_run_counter #(
   parameter int unsigned Target = 8,
   parameter int unsigned Width  = 4
) (
   input  logic             clk_wr,
   input  logic             rst_wr,
   input  logic             inc,
   input  logic             clr,
   input  logic             hold,
   output logic [Width-1:0] count,
   output logic             hit
);

   localparam logic [Width-1:0] Last   = Width'(Target - 1);
   localparam logic [Width-1:0] CntMax = '1;

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         if (count_q != CntMax) count_d = count_q + 1'b1;
      end else if (!hold) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk_wr) begin
      if (rst_wr) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;
   assign hit   = inc && (count_q == Last);

endmodule

// File: rtl/ll_link_bringup.sv
// Link bring-up sequencer: qualifies PHY, aligns on markers, raises tx/rx online, retrains.
module ll_link_bringup
   import ll_bringup_pkg::*;
#(
   parameter int unsigned StableCycles = DefStableCycles,
   parameter int unsigned AlignGood    = DefAlignGood,
   parameter int unsigned AlignTimeout = DefAlignTimeout,
   parameter int unsigned MrkLossMax   = DefMrkLossMax,
   parameter int unsigned RetrainGap   = DefRetrainGap
) (
   input logic               clk_wr,
   input logic               rst_wr,
   ll_link_bringup_if.slave  bus
);

   localparam int unsigned CntW =
      cnt_width(StableCycles, AlignGood, AlignTimeout, MrkLossMax, RetrainGap);

   localparam logic [2:0] StIdle    = BsIdle;
   localparam logic [2:0] StPhyWait = BsPhyWait;
   localparam logic [2:0] StAlign   = BsAlign;
   localparam logic [2:0] StOnline  = BsOnline;
   localparam logic [2:0] StRetrain = BsRetrain;

   logic [2:0]             state_q, state_d;
   logic [CntW-1:0]        tmo_q, tmo_d, gap_q, gap_d;
   logic [RetrainCntW-1:0] retrain_q, retrain_d;
   logic                   terr_q, terr_d;
   logic                   in_pw, in_al, in_on, in_rt, state_chg, tmo_fire;
   logic                   mrk_ok, mrk_err, tmo_hit, gap_hit;
   logic                   stab_hit, good_hit, loss_hit;
   logic [CntW-1:0]        stab_count, good_count, loss_count;

   assign in_pw     = (state_q == StPhyWait);
   assign in_al     = (state_q == StAlign);
   assign in_on     = (state_q == StOnline);
   assign in_rt     = (state_q == StRetrain);
   assign state_chg = (state_d != state_q);
   // A simultaneous ok+err is an error.
   assign mrk_err   = bus.rx_mrk_err;
   assign mrk_ok    = bus.rx_mrk_ok & ~bus.rx_mrk_err;
   assign tmo_hit   = (tmo_q == CntW'(AlignTimeout - 1));
   assign gap_hit   = (gap_q == CntW'(RetrainGap - 1));

   ll_run_counter #(.Target(StableCycles), .Width(CntW)) u_stab (
      .clk_wr (clk_wr),
      .rst_wr (rst_wr),
      .inc    (in_pw & bus.phy_ready),
      .clr    (~in_pw | state_chg),
      .hold   (1'b0),
      .count  (stab_count),
      .hit    (stab_hit)
   );

   ll_run_counter #(.Target(AlignGood), .Width(CntW)) u_good (
      .clk_wr (clk_wr),
      .rst_wr (rst_wr),
      .inc    (in_al & mrk_ok),
      .clr    (~in_al | state_chg | mrk_err),
      .hold   (1'b1),
      .count  (good_count),
      .hit    (good_hit)
   );

   ll_run_counter #(.Target(MrkLossMax), .Width(CntW)) u_loss (
      .clk_wr (clk_wr),
      .rst_wr (rst_wr),
      .inc    (in_on & mrk_err),
      .clr    (~in_on | state_chg | mrk_ok),
      .hold   (1'b1),
      .count  (loss_count),
      .hit    (loss_hit)
   );

   always_comb begin
      state_d  = state_q;
      tmo_fire = 1'b0;
      if (!bus.link_enable) begin
         state_d = StIdle;
      end else if ((in_al || in_on) && !bus.phy_ready) begin
         state_d = StRetrain;
      end else begin
         unique case (state_q)
            StIdle:    state_d = StPhyWait;
            StPhyWait: if (stab_hit) state_d = StAlign;
            StAlign: begin
               if (good_hit) begin
                  state_d = StOnline;
               end else if (tmo_hit) begin
                  state_d  = StRetrain;
                  tmo_fire = 1'b1;
               end
            end
            StOnline:  if (loss_hit) state_d = StRetrain;
            StRetrain: if (gap_hit) state_d = StPhyWait;
            default:   state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      tmo_d     = (in_al && !state_chg) ? tmo_q + 1'b1 : '0;
      gap_d     = (in_rt && !state_chg) ? gap_q + 1'b1 : '0;
      retrain_d = retrain_q;
      if (state_chg && (state_d == StRetrain) && (retrain_q != '1)) retrain_d = retrain_q + 1'b1;
      terr_d    = tmo_fire ? 1'b1 : (bus.err_clr ? 1'b0 : terr_q);
   end

   always_ff @(posedge clk_wr) begin
      if (rst_wr) begin
         state_q   <= StIdle;
         tmo_q     <= '0;
         gap_q     <= '0;
         retrain_q <= '0;
         terr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         gap_q     <= gap_d;
         retrain_q <= retrain_d;
         terr_q    <= terr_d;
      end
   end

   // Run counters always leave their state before reaching their target.
   always_ff @(posedge clk_wr) begin
      if (!rst_wr) begin
         assert (stab_count < CntW'(StableCycles) && good_count < CntW'(AlignGood) &&
                 loss_count < CntW'(MrkLossMax));
      end
   end

   assign bus.tx_online     = in_al | in_on;
   assign bus.rx_online     = in_on;
   assign bus.link_state    = state_q;
   assign bus.timeout_err   = terr_q;
   assign bus.retrain_count = retrain_q;

endmodule

// File: tb/tb_ll_link_bringup.sv
// Directed self-checking bench for ll_link_bringup with default parameters.
module tb_ll_link_bringup;

   logic clk_wr = 1'b0;
   logic rst_wr;
   int   checks = 0;
   int   errors = 0;
   int   n;

   always #5 clk_wr = ~clk_wr;

   ll_link_bringup_if bus_if ();

   ll_link_bringup dut (
      .clk_wr (clk_wr),
      .rst_wr (rst_wr),
      .bus    (bus_if)
   );

   task automatic tick(input int cnt = 1);
      repeat (cnt) @(posedge clk_wr);
      #1;
   endtask

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_tx(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!bus_if.tx_online && cycles < 200);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_tx"},    32'(bus_if.tx_online), 0);
      chk({tag, "_rx"},    32'(bus_if.rx_online), 0);
      chk({tag, "_state"}, 32'(bus_if.link_state), 0);
      chk({tag, "_terr"},  32'(bus_if.timeout_err), 0);
      chk({tag, "_rcnt"},  32'(bus_if.retrain_count), 0);
   endtask

   initial begin
      rst_wr             = 1'b1;
      bus_if.link_enable = 1'b0;
      bus_if.phy_ready   = 1'b0;
      bus_if.rx_mrk_ok   = 1'b0;
      bus_if.rx_mrk_err  = 1'b0;
      bus_if.err_clr     = 1'b0;
      tick(2);
      chk_all_zero("reset");
      rst_wr = 1'b0;

      // Nominal bring-up
      bus_if.link_enable = 1'b1;
      bus_if.phy_ready   = 1'b1;
      wait_tx(n);
      chk("t1_tx_latency", 32'(n), 17);
      chk("t1_align_state", 32'(bus_if.link_state), 2);
      chk("t1_rx_low", 32'(bus_if.rx_online), 0);
      bus_if.rx_mrk_ok = 1'b1;
      tick(7);
      chk("t1_rx_after7", 32'(bus_if.rx_online), 0);
      tick();
      chk("t1_rx_after8", 32'(bus_if.rx_online), 1);
      chk("t1_online_state", 32'(bus_if.link_state), 3);
      chk("t1_tx_online", 32'(bus_if.tx_online), 1);

      // Marker loss: err,err,ok+err | ok | err,err,ok+err stays up; one more err drops
      bus_if.rx_mrk_ok = 1'b0; bus_if.rx_mrk_err = 1'b1;
      tick(2);
      bus_if.rx_mrk_ok = 1'b1;
      tick();
      bus_if.rx_mrk_err = 1'b0;
      tick();
      bus_if.rx_mrk_ok = 1'b0; bus_if.rx_mrk_err = 1'b1;
      tick(2);
      bus_if.rx_mrk_ok = 1'b1;
      tick();
      bus_if.rx_mrk_ok = 1'b0;
      chk("t4_still_online", 32'(bus_if.link_state), 3);
      chk("t4_rx_still_up", 32'(bus_if.rx_online), 1);
      tick();
      bus_if.rx_mrk_err = 1'b0;
      chk("t4_rx_drop", 32'(bus_if.rx_online), 0);
      chk("t4_tx_drop", 32'(bus_if.tx_online), 0);
      chk("t4_retrain_state", 32'(bus_if.link_state), 4);
      chk("t4_retrain_cnt", 32'(bus_if.retrain_count), 1);
      tick(31);
      chk("t4_gap_hold", 32'(bus_if.link_state), 4);
      tick();
      chk("t4_gap_exit", 32'(bus_if.link_state), 1);

      // PHY glitch at stab count 10
      tick(10);
      bus_if.phy_ready = 1'b0;
      tick();
      bus_if.phy_ready = 1'b1;
      chk("t2_still_phywait", 32'(bus_if.link_state), 1);
      wait_tx(n);
      chk("t2_restart_len", 32'(n), 16);
      chk("t2_align_state", 32'(bus_if.link_state), 2);

      // Align timeout, set beats a coincident err_clr
      tick(1023);
      chk("t3_pre_timeout", 32'(bus_if.link_state), 2);
      chk("t3_terr_pre", 32'(bus_if.timeout_err), 0);
      bus_if.err_clr = 1'b1;
      tick();
      chk("t3_retrain_state", 32'(bus_if.link_state), 4);
      chk("t3_terr_set", 32'(bus_if.timeout_err), 1);
      chk("t3_tx_low", 32'(bus_if.tx_online), 0);
      chk("t3_retrain_cnt", 32'(bus_if.retrain_count), 2);
      tick();
      bus_if.err_clr = 1'b0;
      chk("t3_terr_cleared", 32'(bus_if.timeout_err), 0);
      tick(30);
      chk("t3_gap_hold", 32'(bus_if.link_state), 4);
      tick();
      chk("t3_gap_exit", 32'(bus_if.link_state), 1);

      // Priority: disable beats PHY drop while ONLINE
      tick(16);
      chk("t5_align", 32'(bus_if.link_state), 2);
      bus_if.rx_mrk_ok = 1'b1;
      tick(8);
      bus_if.rx_mrk_ok = 1'b0;
      chk("t5_online", 32'(bus_if.link_state), 3);
      bus_if.link_enable = 1'b0;
      bus_if.phy_ready   = 1'b0;
      tick();
      chk("t5_idle", 32'(bus_if.link_state), 0);
      chk("t5_retrain_same", 32'(bus_if.retrain_count), 2);
      chk("t5_rx_low", 32'(bus_if.rx_online), 0);

      // Saturation via PHY drops in ALIGN
      bus_if.link_enable = 1'b1;
      bus_if.phy_ready   = 1'b1;
      tick(17);
      chk("t6_align", 32'(bus_if.link_state), 2);
      for (int i = 0; i < 260; i++) begin
         bus_if.phy_ready = 1'b0;
         tick();
         bus_if.phy_ready = 1'b1;
         tick(48);
         if (i == 251) chk("t6_cnt_254", 32'(bus_if.retrain_count), 254);
         if (i == 252) chk("t6_cnt_255", 32'(bus_if.retrain_count), 255);
      end
      chk("t6_cnt_sat", 32'(bus_if.retrain_count), 255);
      chk("t6_align_again", 32'(bus_if.link_state), 2);

      // Reset mid-ALIGN with partial good run
      bus_if.rx_mrk_ok = 1'b1;
      tick(3);
      rst_wr = 1'b1;
      tick();
      chk_all_zero("t6_rst");
      rst_wr = 1'b0;
      bus_if.rx_mrk_ok = 1'b0;
      tick(17);
      chk("t6_rst_align", 32'(bus_if.link_state), 2);
      bus_if.rx_mrk_ok = 1'b1;
      tick(7);
      chk("t6_no_partial", 32'(bus_if.link_state), 2);
      tick();
      chk("t6_online", 32'(bus_if.link_state), 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
